mul_result_buffer: RTL and testbench
====================================

# mul_result_buffer

Issue-side and writeback-side wrapper for the 4-stage pipelined multiplier in the Tomasulo execution cluster. Accepts tagged multiply ops from the MUL reservation station and drives the multiplier's operand inputs. Because the multiplier cannot stall, this block tracks each op's ROB tag alongside it, buffers completed results in a FIFO until the CDB grants, and throttles issue with credits so no result is ever lost.

## Interface
- TAG_W, 4: ROB tag width.
- DEPTH, 4: result FIFO entries; also the total credit limit, counting in-flight plus buffered ops.
- LAT, 4: multiplier latency in cycles from `mul_valid_i` to `valid_o`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  RS presents an op.
- in_ready  out  1  block can accept.
- in_tag  in  TAG_W  ROB tag.
- in_op1, in_op2  in  32  operands.
- in_mode  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- flush  in  1  mispredict flush; kills everything held or in flight.
- mul_valid_i  out  1  to multiplier `valid_i`.
- mul_op1, mul_op2  out  32  to multiplier.
- mul_mode  out  2  to multiplier.
- mul_valid_o  in  1  from multiplier `valid_o`.
- mul_result  in  32  from multiplier `result_o`.
- cdb_valid  out  1  result available.
- cdb_ready  in  1  CDB grant.
- cdb_tag  out  TAG_W  result tag.
- cdb_data  out  32  result value.

## Operation
- **Accept:** an op is accepted when `in_valid && in_ready`.
  - `mul_valid_i = in_valid && in_ready`.
  - `mul_op1`, `mul_op2` and `mul_mode` are combinational pass-throughs of the `in_*` signals.
- **Credit:** `inflight` is the number of valid tag-pipe entries, killed entries included. `fifo_count` is the FIFO occupancy.
  - `in_ready = !flush && (inflight + fifo_count < DEPTH)`.
  - Both counts are registered values. A same-cycle CDB pop does not free a credit until the next cycle.
- **Tag pipe:** LAT-stage shift register of {valid, kill, tag}.
  - Stage 0 loads {1, 0, in_tag} on accept and {0, x, x} otherwise.
  - Stage LAT-1 is the head and pairs with `mul_valid_o` in the same cycle.
- **Retire:** when `mul_valid_o` is high:
  - If the head is killed, or `flush` is high this cycle, the result is dropped.
  - Otherwise {head tag, `mul_result`} is pushed into the FIFO.
  - `mul_valid_o` high with the head invalid is a protocol error. The bench flags it; the RTL ignores the result.
- **FIFO:** circular buffer with wrapping read/write pointers and a count.
  - Push and pop in the same cycle leaves the count unchanged.
  - Overflow is impossible by construction of the credit rule. The bench asserts this.
  - Results leave in issue order, because multiplier latency is fixed.
- **CDB:**
  - `cdb_valid = (fifo_count != 0) && !flush`.
  - `cdb_tag` and `cdb_data` come from the FIFO head.
  - Pop occurs on `cdb_valid && cdb_ready`.
  - `cdb_tag`/`cdb_data` are don't-care while `cdb_valid` is low.
- **Flush:**
  - In the flush cycle, the FIFO empties (pointers and count go to 0) and every tag-pipe entry gets kill=1.
  - Killed entries keep shifting and keep consuming credit until they reach the head.
  - No CDB pop occurs during flush.

## Timing
- Accept in cycle N: `mul_valid_o` arrives in cycle N+LAT and the FIFO is written at the end of that cycle. `cdb_valid` is high from cycle N+LAT+1.
- Issue-to-CDB latency is LAT+1 cycles when there is no backpressure.
- Throughput is one op per cycle while credits remain.
- Reset, asynchronous, gives:
  - all tag-pipe valid=0;
  - FIFO pointers and count = 0;
  - `cdb_valid`=0;
  - `in_ready`=1 once `rst` deasserts, provided `flush` is low;
  - `mul_valid_i`=0.
- Reset mid-operation discards all in-flight and buffered ops. The multiplier is reset on the same `rst`, so no stale `mul_valid_o` follows.

## Configuration
- **MUL_RB_BYPASS_EN defined:**
  - When the FIFO is empty, `mul_valid_o` is high, the head is live and `flush` is low, the block drives `cdb_valid`/`cdb_tag`/`cdb_data` combinationally from {head tag, `mul_result`}.
  - If `cdb_ready` is high, the FIFO is not written. Latency becomes LAT cycles.
  - If `cdb_ready` is low, the result is pushed as normal.
- **Undefined:** every result passes through the FIFO, giving a latency of LAT+1.

## Test plan
- **Single MUL:** op1=7, op2=-3 (0xFFFFFFFD), mode 00, tag 5, `cdb_ready`=1 → `cdb_valid` high in cycle N+5 (N+4 with bypass), tag 5, data 0xFFFFFFEB; single-cycle pulse.
- **Backpressure:** `cdb_ready`=0; issue 6 back-to-back MULHU ops with op1=op2=0xFFFFFFFF, tags 0..5 → exactly 4 accepted and `in_ready` low from the 5th cycle. Then raise `cdb_ready` → tags 0,1,2,3 each carry data 0xFFFFFFFE; `in_ready` reasserts the cycle after the first pop.
- **Flush mid-flight:** accept tags 1,2,3 on consecutive cycles, assert `flush` 2 cycles later → no CDB output for tags 1–3. `in_ready` stays low until the credit rule permits, and a tag 9 accepted after flush retires normally.
- **Simultaneous push and pop with wrap:** steady stream of 20 MULH ops with alternating `cdb_ready` → results appear in order with correct upper-32 values, `fifo_count` never exceeds 4, and pointers wrap correctly.
- **Reset mid-operation:** assert `rst` with 2 ops in flight and 2 buffered → `cdb_valid` goes 0 immediately (asynchronously) and stays 0 after release; the next op retires with the correct tag.
- **MULHSU sign handling:** op1=0x80000000, op2=0xFFFFFFFF, mode 10 → data 0x80000000.

Source files
------------

// File: rtl/mul_result_buffer.sv
// -----------------------------------------------------------------------------
// mul_result_buffer
//
// Issue/writeback wrapper around the fixed-latency, non-stallable pipelined
// multiplier of the Tomasulo execution cluster. Ops accepted from the MUL
// reservation station go straight to the multiplier. Each op's ROB tag travels
// alongside it in a tag pipe. Completed results are parked in a small FIFO
// until the CDB grants. A credit rule limits in-flight plus buffered ops to
// DEPTH, so a result is never lost.
//
// Optional feature macro: MUL_RB_BYPASS_EN
//   When defined, a result arriving while the FIFO is empty is presented on the
//   CDB in the same cycle (latency LAT). If it is granted, it is never
//   written into the FIFO.
//   When undefined, every result goes through the FIFO (latency LAT+1).
//
// Parameters
//   TAG_W : ROB tag width
//   DEPTH : result FIFO entries; also the total credit limit
//   LAT   : multiplier latency, from mul_valid_i to mul_valid_o
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid / in_ready      RS handshake
//   in_tag, in_op1, in_op2   ROB tag and operands of the presented op
//   in_mode                  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   flush                    mispredict flush; kills all held/in-flight ops
//   mul_valid_i, mul_op1,
//   mul_op2, mul_mode        issue side of the multiplier
//   mul_valid_o, mul_result  completion side of the multiplier
//   cdb_valid / cdb_ready    CDB handshake
//   cdb_tag, cdb_data        result presented to the CDB
// -----------------------------------------------------------------------------
module mul_result_buffer #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4,
  parameter int LAT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             mul_valid_i,
  output logic [31:0]      mul_op1,
  output logic [31:0]      mul_op2,
  output logic [1:0]       mul_mode,
  input  logic             mul_valid_o,
  input  logic [31:0]      mul_result,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(LAT + 1);
  localparam int CRD_W = $clog2(LAT + DEPTH + 1);

  // Tag pipe: stage LAT-1 is the head and lines up with mul_valid_o.
  logic [LAT-1:0]   r_tp_vld;
  logic [LAT-1:0]   r_tp_kill;
  logic [TAG_W-1:0] r_tp_tag [LAT];

  // Result FIFO.
  logic [TAG_W-1:0] r_fifo_tag  [DEPTH];
  logic [31:0]      r_fifo_data [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [INF_W-1:0] w_inflight;
  logic [CRD_W-1:0] w_credit_used;
  logic             w_accept;
  logic             w_head_live;
  logic             w_retire;
  logic             w_bypass;
  logic             w_fifo_vld;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Killed entries still count: their results will still come out of the
  // multiplier, so the slot must stay reserved until they reach the head.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + INF_W'(r_tp_vld[i]);
    end
  end

  assign w_credit_used = CRD_W'(w_inflight) + CRD_W'(r_count);
  assign in_ready      = !flush && (w_credit_used < CRD_W'(DEPTH));
  assign w_accept      = in_valid && in_ready;

  assign mul_valid_i = w_accept;
  assign mul_op1     = in_op1;
  assign mul_op2     = in_op2;
  assign mul_mode    = in_mode;

  // A result retires only if its head entry is live and no flush is under way.
  // mul_valid_o against an empty head is a protocol error; it is dropped here.
  assign w_head_live = r_tp_vld[LAT-1] && !r_tp_kill[LAT-1];
  assign w_retire    = mul_valid_o && w_head_live && !flush;

`ifdef MUL_RB_BYPASS_EN
  assign w_bypass = w_retire && (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_vld = (r_count != '0) && !flush;
  assign cdb_valid  = w_fifo_vld || w_bypass;
  assign cdb_tag    = w_fifo_vld ? r_fifo_tag[r_rd_ptr]  : r_tp_tag[LAT-1];
  assign cdb_data   = w_fifo_vld ? r_fifo_data[r_rd_ptr] : mul_result;

  // A granted bypass result skips the FIFO entirely.
  assign w_pop  = w_fifo_vld && cdb_ready;
  assign w_push = w_retire && !(w_bypass && cdb_ready);

  // ---- tag pipe: control ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tp_vld  <= '0;
      r_tp_kill <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        r_tp_vld[i]  <= r_tp_vld[i-1];
        r_tp_kill[i] <= r_tp_kill[i-1] | flush;
      end
      r_tp_vld[0]  <= w_accept;
      r_tp_kill[0] <= 1'b0;
    end
  end

  // ---- tag pipe: data ----
  always_ff @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      r_tp_tag[i] <= r_tp_tag[i-1];
    end
    r_tp_tag[0] <= in_tag;
  end

  // ---- FIFO: pointers and count ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- FIFO: storage ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_tag[r_wr_ptr]  <= r_tp_tag[LAT-1];
      r_fifo_data[r_wr_ptr] <= mul_result;
    end
  end

endmodule

// File: tb/tb_mul_result_buffer.sv
module tb_mul_result_buffer;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;
`ifdef MUL_RB_BYPASS_EN
  localparam int EXP_LAT = LAT;
`else
  localparam int EXP_LAT = LAT + 1;
`endif

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      in_op1 = '0;
  logic [31:0]      in_op2 = '0;
  logic [1:0]       in_mode = '0;
  logic             flush = 1'b0;
  logic             mul_valid_i;
  logic [31:0]      mul_op1;
  logic [31:0]      mul_op2;
  logic [1:0]       mul_mode;
  logic             mul_valid_o;
  logic [31:0]      mul_result;
  logic             cdb_valid;
  logic             cdb_ready = 1'b0;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_popped = 0;
  int   max_cnt  = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  mul_result_buffer #(.TAG_W(TAG_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_op1(in_op1), .in_op2(in_op2), .in_mode(in_mode),
    .flush(flush),
    .mul_valid_i(mul_valid_i), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_mode(mul_mode),
    .mul_valid_o(mul_valid_o), .mul_result(mul_result),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  // Multiplier stand-in: LAT-stage pipeline, reset together with the DUT.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] m);
    logic signed [32:0] sa;
    logic signed [32:0] sb;
    logic signed [65:0] p;
    sa = {(m == 2'b01 || m == 2'b10) & a[31], a};
    sb = {(m == 2'b01) & b[31], b};
    p  = sa * sb;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  logic [LAT-1:0] m_vld;
  logic [31:0]    m_res [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) m_vld <= '0;
    else     m_vld <= {m_vld[LAT-2:0], mul_valid_i};
  end

  always_ff @(posedge clk) begin
    m_res[0] <= mul_model(mul_op1, mul_op2, mul_mode);
    for (int i = 1; i < LAT; i++) m_res[i] <= m_res[i-1];
  end

  assign mul_valid_o = m_vld[LAT-1];
  assign mul_result  = m_res[LAT-1];

  // Scoreboard reference: two's-complement product in 64-bit modular arithmetic.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = {(m != 2'b11) ? {32{a[31]}} : 32'h0, a};
    eb = {(m == 2'b01) ? {32{b[31]}} : 32'h0, b};
    p  = ea * eb;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (cdb_valid && cdb_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fails++;
          $display("FAIL sb_unexpected: got tag %0d data %h, expected no output", cdb_tag, cdb_data);
        end else begin
          res_t e;
          e = sb_q.pop_front();
          n_popped++;
          if ({cdb_tag, cdb_data} !== e) begin
            n_fails++;
            $display("FAIL sb_result: got tag %0d data %h, expected tag %0d data %h",
                     cdb_tag, cdb_data, e.tag, e.data);
          end
        end
      end
      if (flush) sb_q.delete();
      if (in_valid && in_ready) sb_q.push_back({in_tag, ref_mul(in_op1, in_op2, in_mode)});
      if (mul_valid_o) begin
        n_checks++;
        if (dut.r_tp_vld[LAT-1] !== 1'b1) begin
          n_fails++;
          $display("FAIL protocol: mul_valid_o with head valid %b, expected 1", dut.r_tp_vld[LAT-1]);
        end
      end
      if (int'(dut.r_count) > max_cnt) max_cnt = int'(dut.r_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (cdb_valid !== 1'b0) begin n_fails++; $display("FAIL rst_cdb_valid: got %b expected 0", cdb_valid); end
    n_checks++;
    if (mul_valid_i !== 1'b0) begin n_fails++; $display("FAIL rst_mul_valid_i: got %b expected 0", mul_valid_i); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (cdb_valid !== 1'b0) begin n_fails++; $display("FAIL post_rst_cdb_valid: got %b expected 0", cdb_valid); end
    flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fails++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    flush = 1'b0;
    tick();
  endtask

  task automatic test_single_mul();
    int first;
    logic [TAG_W-1:0] t_s;
    logic [31:0] d_s;
    logic nxt;
    first = -1; t_s = '0; d_s = '0; nxt = 1'b1;
    cdb_ready = 1'b1;
    in_valid = 1'b1; in_tag = 4'd5; in_op1 = 32'd7; in_op2 = 32'hFFFFFFFD; in_mode = 2'b00;
    #1;
    n_checks++;
    if ({mul_valid_i, mul_op1, mul_op2, mul_mode} !== {1'b1, 32'd7, 32'hFFFFFFFD, 2'b00}) begin
      n_fails++;
      $display("FAIL issue_passthru: got %b %h %h %b expected 1 00000007 fffffffd 00",
               mul_valid_i, mul_op1, mul_op2, mul_mode);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (first >= 0 && k == first + 1) nxt = cdb_valid;
      if (cdb_valid && first < 0) begin first = k; t_s = cdb_tag; d_s = cdb_data; end
      tick();
    end
    n_checks++;
    if (first != EXP_LAT) begin n_fails++; $display("FAIL single_latency: got %0d expected %0d", first, EXP_LAT); end
    n_checks++;
    if (t_s !== 4'd5) begin n_fails++; $display("FAIL single_tag: got %0d expected 5", t_s); end
    n_checks++;
    if (d_s !== 32'hFFFFFFEB) begin n_fails++; $display("FAIL single_data: got %h expected ffffffeb", d_s); end
    n_checks++;
    if (nxt !== 1'b0) begin n_fails++; $display("FAIL single_pulse: got %b expected 0", nxt); end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [5:0] rdy;
    acc = 0; rdy = '0;
    cdb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_tag = TAG_W'(i);
      in_op1 = 32'hFFFFFFFF; in_op2 = 32'hFFFFFFFF; in_mode = 2'b11;
      #1;
      rdy[i] = in_ready;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc != DEPTH) begin n_fails++; $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH); end
    n_checks++;
    if (rdy !== 6'b001111) begin n_fails++; $display("FAIL bp_ready_pattern: got %b expected 001111", rdy); end
    repeat (4) tick();
    n_checks++;
    if ({in_ready, cdb_valid} !== 2'b01) begin
      n_fails++; $display("FAIL bp_full: got ready %b valid %b expected 0 1", in_ready, cdb_valid);
    end
    cdb_ready = 1'b1;
    #1;
    n_checks++;
    if ({cdb_tag, cdb_data, in_ready} !== {4'd0, 32'hFFFFFFFE, 1'b0}) begin
      n_fails++; $display("FAIL bp_first_pop: got tag %0d data %h ready %b expected 0 fffffffe 0",
                          cdb_tag, cdb_data, in_ready);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_ready_return: got %b expected 1", in_ready); end
    for (int t = 1; t < 4; t++) begin
      n_checks++;
      if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, TAG_W'(t), 32'hFFFFFFFE}) begin
        n_fails++; $display("FAIL bp_drain: got v %b tag %0d data %h expected 1 %0d fffffffe",
                            cdb_valid, cdb_tag, cdb_data, t);
      end
      tick();
    end
    n_checks++;
    if (cdb_valid !== 1'b0) begin n_fails++; $display("FAIL bp_empty: got %b expected 0", cdb_valid); end
  endtask

  task automatic test_flush();
    int bad;
    int first;
    bad = 0; first = -1;
    cdb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = TAG_W'(i + 1);
      in_op1 = 32'(i + 1); in_op2 = 32'd3; in_mode = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, cdb_valid} !== 2'b00) begin
      n_fails++; $display("FAIL flush_cycle: got ready %b valid %b expected 0 0", in_ready, cdb_valid);
    end
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL flush_credit: got %b expected 1", in_ready); end
    in_valid = 1'b1; in_tag = 4'd9; in_op1 = 32'd6; in_op2 = 32'd7; in_mode = 2'b00;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (cdb_valid && cdb_tag >= 4'd1 && cdb_tag <= 4'd3) bad++;
      if (cdb_valid && cdb_tag == 4'd9 && cdb_data == 32'd42 && first < 0) first = k;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fails++; $display("FAIL flush_killed_out: got %0d expected 0", bad); end
    n_checks++;
    if (first != EXP_LAT) begin n_fails++; $display("FAIL flush_tag9: got cycle %0d expected %0d", first, EXP_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [20];
    logic [31:0] b [20];
    int acc;
    int cyc;
    int pop0;
    a[0] = 32'h80000000; b[0] = 32'h80000000;
    a[1] = 32'hFFFFFFFF; b[1] = 32'h00000001;
    for (int i = 2; i < 20; i++) begin a[i] = $urandom; b[i] = $urandom; end
    acc = 0; cyc = 0; pop0 = n_popped; max_cnt = 0;
    while (acc < 20 && cyc < 200) begin
      in_valid = 1'b1; in_tag = TAG_W'(acc); in_op1 = a[acc]; in_op2 = b[acc]; in_mode = 2'b01;
      cdb_ready = cyc[0];
      #1;
      if (in_ready) acc++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    cdb_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 50) begin tick(); cyc++; end
    n_checks++;
    if (acc != 20) begin n_fails++; $display("FAIL b2b_accepted: got %0d expected 20", acc); end
    n_checks++;
    if (n_popped - pop0 != 20) begin n_fails++; $display("FAIL b2b_popped: got %0d expected 20", n_popped - pop0); end
    n_checks++;
    if (max_cnt > DEPTH) begin n_fails++; $display("FAIL b2b_overflow: got %0d expected <= %0d", max_cnt, DEPTH); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int first;
    seen = 1'b0; first = -1;
    cdb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_tag = TAG_W'(12 + i); in_op1 = 32'(i + 2); in_op2 = 32'd9; in_mode = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (cdb_valid !== 1'b1) begin n_fails++; $display("FAIL rmid_pre: got %b expected 1", cdb_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (cdb_valid !== 1'b0) begin n_fails++; $display("FAIL rmid_async: got %b expected 0", cdb_valid); end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (cdb_valid) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fails++; $display("FAIL rmid_stale: got %b expected 0", seen); end
    cdb_ready = 1'b1;
    in_valid = 1'b1; in_tag = 4'd11; in_op1 = 32'd5; in_op2 = 32'd5; in_mode = 2'b00;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (cdb_valid && first < 0 && cdb_tag == 4'd11 && cdb_data == 32'd25) first = k;
      tick();
    end
    n_checks++;
    if (first != EXP_LAT) begin n_fails++; $display("FAIL rmid_next: got cycle %0d expected %0d", first, EXP_LAT); end
  endtask

  task automatic test_mulhsu();
    int first;
    logic [31:0] d_s;
    first = -1; d_s = '0;
    cdb_ready = 1'b1;
    in_valid = 1'b1; in_tag = 4'd7; in_op1 = 32'h80000000; in_op2 = 32'hFFFFFFFF; in_mode = 2'b10;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (cdb_valid && first < 0 && cdb_tag == 4'd7) begin first = k; d_s = cdb_data; end
      tick();
    end
    n_checks++;
    if (first != EXP_LAT) begin n_fails++; $display("FAIL mulhsu_latency: got %0d expected %0d", first, EXP_LAT); end
    n_checks++;
    if (d_s !== 32'h80000000) begin n_fails++; $display("FAIL mulhsu_data: got %h expected 80000000", d_s); end
  endtask

  initial begin
    test_reset();
    test_single_mul();
    repeat (3) tick();
    test_backpressure();
    repeat (3) tick();
    test_flush();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_reset_mid();
    repeat (3) tick();
    test_mulhsu();
    repeat (3) tick();
    n_checks++;
    if (sb_q.size() != 0) begin n_fails++; $display("FAIL sb_leftover: got %0d expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
